ram_port_master: RTL and testbench

//  Initiator side of the single-port 16-bit block RAM interface (1-cycle registered read, write on i_we).

---
 rtl/ram_port_master_pkg.sv | 24 ++
 rtl/rsp_fifo2.sv | 49 ++++
 rtl/ram_port_master.sv | 98 +++++++++
 tb/tb_ram_port_master.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_master_pkg.sv
// ram_port_master_pkg: shared widths, FSM encoding and credit helper
// for the single-port block RAM initiator.
package ram_port_master_pkg;

  localparam int RPM_ADDR_W = 13;
  localparam int RPM_DATA_W = 16;
  localparam int RPM_DEPTH  = 8192;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Slots that will be occupied after this edge:
  // buffered + in flight - leaving.
  function automatic logic [2:0] occupancy(
    input logic [1:0] cnt,
    input logic       pend,
    input logic       pop
  );
    return 3'(cnt) + 3'(pend) - 3'(pop);
  endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// rsp_fifo2: two-entry response buffer for load data,
// async active-low reset, push/pop/count.
module rsp_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wp_q;
  logic              rp_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= wdata_i;
        wp_q        <= ~wp_q;
      end
      if (do_pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign rdata_o = mem_q[rp_q];
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ram_port_master.sv
// ram_port_master: CPU load/store initiator for a 1-cycle
// registered block RAM, with optional zero-fill after reset.
module ram_port_master
  import ram_port_master_pkg::*;
#(
  parameter int ADDR_W         = RPM_ADDR_W,
  parameter int DATA_W         = RPM_DATA_W,
  parameter int DEPTH          = RPM_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_busy,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam state_e ST_RST = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [1:0]        fcount;
  logic              pop;
  logic              acc;

  assign pop = o_rsp_valid && i_rsp_ready;
  assign acc = i_req_valid && o_req_ready;

  // Reset gates the handshake so nothing leaks out while held.
  assign o_req_ready = rst && (state_q == ST_RUN)
                    && (occupancy(fcount, pend_q, pop) < 3'd2);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    o_busy      = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = i_req_addr;
    o_ram_wdata = i_req_wdata;
    unique case (state_q)
      ST_CLEAR: begin
        o_busy      = 1'b1;
        o_ram_we    = rst;
        o_ram_addr  = cnt_q;
        o_ram_wdata = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_ram_we = acc && i_req_we;
        pend_d   = acc && !i_req_we;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // RAM data is valid the cycle after a load is accepted.
  rsp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_rsp (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (pend_q),
    .wdata_i (i_ram_rdata),
    .pop_i   (i_rsp_ready),
    .rdata_o (o_rsp_rdata),
    .valid_o (o_rsp_valid),
    .count_o (fcount)
  );

endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: drives ram_port_master against an 8192x16
// block RAM model and a memory/queue reference model.
module tb_ram_port_master;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          i_req_we = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0;
  logic          i_rsp_ready = 1'b0;
  logic          o_req_ready;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_busy;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_master dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_busy      (o_busy),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_wdata (o_ram_wdata),
    .i_ram_rdata (i_ram_rdata)
  );

  // Block RAM: seeded with garbage, registered read.
  logic [DW-1:0] ram [DEPTH];
  bit ram_seeded = 1'b0;
  always @(posedge clk) begin
    if (!ram_seeded) begin
      foreach (ram[i]) ram[i] <= DW'($urandom);
      ram_seeded <= 1'b1;
    end else begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
      i_ram_rdata <= ram[o_ram_addr];
    end
  end

  // Reference: reset zero-fills memory; loads return memory
  // contents at accept time, in order.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            acc_cyc [$];
  int            got_cyc [$];
  int            cyc = 0;

  always @(posedge clk) begin
    if (!rst) begin
      foreach (model_mem[i]) model_mem[i] <= '0;
      exp_q.delete();
      got_q.delete();
      acc_cyc.delete();
      got_cyc.delete();
    end else begin
      if (i_req_valid && o_req_ready) begin
        if (i_req_we) begin
          model_mem[i_req_addr] <= i_req_wdata;
        end else begin
          exp_q.push_back(model_mem[i_req_addr]);
          acc_cyc.push_back(cyc);
        end
      end
      if (o_rsp_valid && i_rsp_ready) begin
        got_q.push_back(o_rsp_rdata);
        got_cyc.push_back(cyc);
      end
    end
    cyc <= cyc + 1;
  end

  task automatic issue(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int w = 0;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = a;
    i_req_wdata = d;
    #1;
    while (!o_req_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++;
    if (!o_req_ready) begin
      failures++;
      $display("FAIL issue_ready addr=%h got=%0b want=1", a, o_req_ready);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (o_busy && n < 10000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (got_q.size() < exp_q.size() && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    int n;
    int nz;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_busy, o_req_ready, o_rsp_valid, o_ram_we} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=1000",
               {o_busy, o_req_ready, o_rsp_valid, o_ram_we});
    end
    @(negedge clk);
    rst = 1'b1;
    wait_clear(n);
    checks++;
    if (n !== DEPTH) begin
      failures++;
      $display("FAIL clear_cycles got=%0d want=%0d", n, DEPTH);
    end
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_clear got=%b want=1", o_req_ready);
    end
    nz = 0;
    foreach (ram[i]) if (ram[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL ram_zeroed nonzero_words got=%0d want=0", nz);
    end
    @(negedge clk);
    i_rsp_ready = 1'b1;
    issue(1'b0, 13'h1FFF, '0);
    wait_drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin
      failures++;
      $display("FAIL load_top got=%h n=%0d want=0000",
               got_q.size() ? got_q[0] : 16'hxxxx, got_q.size());
    end
  endtask

  task automatic test_store_load();
    int base;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    issue(1'b1, 13'h0123, 16'hBEEF);
    issue(1'b0, 13'h0123, '0);
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_early got=%b want=0", o_rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL store_load got=%b/%h want=1/beef",
               o_rsp_valid, o_rsp_rdata);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a = AW'($urandom);
      d = DW'($urandom);
      base = exp_q.size();
      issue(1'b1, a, d);
      issue(1'b0, a, '0);
      wait_drain();
      checks++;
      if (got_q.size() <= base || got_q[base] !== d ||
          got_q[base] !== exp_q[base]) begin
        failures++;
        $display("FAIL rand_store_load addr=%h got=%h want=%h", a,
                 got_q.size() > base ? got_q[base] : 16'hxxxx, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int bad;
    for (int k = 0; k < 8; k++) issue(1'b1, AW'(16 + k), DW'($urandom));
    base = exp_q.size();
    for (int k = 0; k < 8; k++) issue(1'b0, AW'(16 + k), '0);
    wait_drain();
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (got_q.size() <= base + k || got_q[base + k] !== exp_q[base + k])
        bad++;
      else if (k > 0 && got_cyc[base + k] != got_cyc[base + k - 1] + 1)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_order bad_entries got=%0d want=0", bad);
    end
    checks++;
    if (got_q.size() <= base ||
        got_cyc[base] != acc_cyc[base] + 2) begin
      failures++;
      $display("FAIL b2b_latency got=%0d want=2",
               got_q.size() > base ? got_cyc[base] - acc_cyc[base] : -1);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int bad;
    logic [DW-1:0] head;
    base = exp_q.size();
    i_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1;
      i_req_we    = 1'b0;
      i_req_addr  = AW'(16 + $urandom_range(0, 7));
      if (k < 2) @(negedge clk);
    end
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got=%b want=0", o_req_ready);
    end
    head = exp_q.size() > base ? exp_q[base] : 'x;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (o_req_ready !== 1'b0 || o_rsp_valid !== 1'b1 ||
          o_rsp_rdata !== head) bad++;
    end
    checks++;
    if (bad != 0 || exp_q.size() != base + 2) begin
      failures++;
      $display("FAIL hold_stable bad=%0d accepted=%0d want=0/2",
               bad, exp_q.size() - base);
    end
    i_rsp_ready = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_on_pop got=%b want=1", o_req_ready);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    wait_drain();
    bad = 0;
    for (int k = 0; k < 3; k++)
      if (got_q.size() <= base + k || got_q[base + k] !== exp_q[base + k])
        bad++;
    checks++;
    if (bad != 0 || exp_q.size() != base + 3) begin
      failures++;
      $display("FAIL bp_order bad=%0d accepted=%0d want=0/3",
               bad, exp_q.size() - base);
    end
  endtask

  task automatic test_random();
    int base;
    int bad;
    logic acc;
    base = exp_q.size();
    acc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      i_rsp_ready = 1'($urandom);
      if (acc || !i_req_valid) begin
        i_req_valid = 1'($urandom);
        i_req_we    = 1'($urandom);
        i_req_addr  = AW'($urandom_range(0, 31));
        i_req_wdata = DW'($urandom);
      end
      #1;
      acc = i_req_valid && o_req_ready;
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    wait_drain();
    bad = 0;
    for (int k = base; k < exp_q.size(); k++)
      if (got_q.size() <= k || got_q[k] !== exp_q[k]) bad++;
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_traffic bad=%0d got=%0d want=%0d",
               bad, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_clear_restart();
    int k;
    int n;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k = 0;
    #1;
    while (o_ram_addr !== 13'h0800 && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (k != 'h800 || o_ram_we !== 1'b1) begin
      failures++;
      $display("FAIL sweep_progress cycles=%0d we=%b want=2048/1", k, o_ram_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_req_ready, o_rsp_valid, o_ram_we} !== 4'b1000 ||
        o_ram_addr !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b addr=%h want=1000 addr=0000",
               {o_busy, o_req_ready, o_rsp_valid, o_ram_we}, o_ram_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (o_ram_addr !== '0 || o_ram_we !== 1'b1 || o_ram_wdata !== '0) begin
      failures++;
      $display("FAIL sweep_restart addr=%h we=%b want=0000/1",
               o_ram_addr, o_ram_we);
    end
    @(negedge clk);
    wait_clear(n);
    checks++;
    if (n + 1 != DEPTH) begin
      failures++;
      $display("FAIL restart_cycles got=%0d want=%0d", n + 1, DEPTH);
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    int stale;
    i_rsp_ready = 1'b0;
    issue(1'b1, 13'h0123, 16'hBEEF);
    issue(1'b0, 13'h0123, '0);
    issue(1'b0, 13'h0017, '0);
    #1;
    checks++;
    if (o_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL inflight_setup got=%b want=1", o_rsp_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL inflight_reset valid=%b ready=%b want=0/0",
               o_rsp_valid, o_req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    i_rsp_ready = 1'b1;
    n = 0;
    stale = 0;
    while (o_busy && n < 10000) begin
      if (o_rsp_valid) stale++;
      n++;
      @(negedge clk);
    end
    repeat (4) begin
      if (o_rsp_valid) stale++;
      @(negedge clk);
    end
    checks++;
    if (stale != 0 || got_q.size() != 0 || n != DEPTH) begin
      failures++;
      $display("FAIL stale_rsp stale=%0d rsp=%0d sweep=%0d want=0/0/%0d",
               stale, got_q.size(), n, DEPTH);
    end
    issue(1'b0, 13'h0123, '0);
    wait_drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin
      failures++;
      $display("FAIL cleared_word got=%h want=0000",
               got_q.size() ? got_q[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_clear_restart();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
